// File: rtl/regex_line_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : regex_line_streamer_if
// Description : Line-in / result-out handshake bundle for regex_line_streamer.
// Revision    : 1.0 - initial release
// ============================================================================
interface regex_line_streamer_if #(
    parameter int WIDTH  = 21,
    parameter int LINE_W = 14
);
    logic [WIDTH-1:0]  line_data;
    logic              line_valid;
    logic              line_ready;
    logic              res_valid;
    logic              res_ready;
    logic              res_match;
    logic [LINE_W-1:0] res_line;

    modport master (
        output line_data, line_valid, res_ready,
        input  line_ready, res_valid, res_match, res_line
    );

    modport slave (
        input  line_data, line_valid, res_ready,
        output line_ready, res_valid, res_match, res_line
    );
endinterface
`default_nettype wire

// File: rtl/regex_line_streamer.sv
`default_nettype none
// ============================================================================
// Module      : regex_line_streamer
// Description : Serializes WIDTH-bit lines MSB-first into the serial regex
//               matcher and returns a line-numbered match result per line.
// Revision    : 1.0 - initial release
// ============================================================================
module regex_line_streamer #(
    parameter int WIDTH  = 21,
    parameter int LINE_W = 14,
    parameter int CNT_W  = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    regex_line_streamer_if.slave  lines,
    output logic                  ser_en,
    output logic                  ser_bit,
    input  wire logic             match_in,
    output logic [CNT_W-1:0]      match_count,
    output logic                  busy
);

    localparam int              c_BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_BIT_W-1:0] c_LAST = c_BIT_W'(WIDTH - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_GAP    = 3'd1;
    localparam logic [2:0] c_SHIFT  = 3'd2;
    localparam logic [2:0] c_SAMPLE = 3'd3;
    localparam logic [2:0] c_RESULT = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [WIDTH-1:0]   r_shift;
    logic [c_BIT_W-1:0] r_bit_idx;
    logic               r_ser_en;
    logic               r_ser_bit;
    logic               r_line_ready;
    logic               r_res_valid;
    logic               r_res_match;
    logic               r_busy;
    logic [LINE_W-1:0]  r_line_cnt;
    logic [CNT_W-1:0]   r_match_cnt;

    logic               w_accept;
    logic               w_res_done;
    logic               w_ser_bit;
    logic               w_line_ready;
    logic               w_res_valid;
    logic               w_busy;

    assign w_accept   = (r_state == c_IDLE) && lines.line_valid && r_line_ready;
    assign w_res_done = (r_state == c_RESULT) && r_res_valid && lines.res_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:   if (w_accept) w_next_state = c_GAP;
            c_GAP:    w_next_state = c_SHIFT;
            c_SHIFT:  if (r_bit_idx == c_LAST) w_next_state = c_SAMPLE;
            c_SAMPLE: w_next_state = c_RESULT;
            c_RESULT: if (w_res_done) w_next_state = c_IDLE;
            default:  w_next_state = c_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so their registers line up with r_state.
    always_comb begin
        w_line_ready = (w_next_state == c_IDLE);
        w_busy       = (w_next_state != c_IDLE);
        w_res_valid  = (w_next_state == c_RESULT);
        w_ser_bit    = (w_next_state == c_SHIFT) ? r_shift[WIDTH-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ser_en     <= 1'b0;
            r_ser_bit    <= 1'b0;
            r_line_ready <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_match  <= 1'b0;
            r_busy       <= 1'b0;
            r_line_cnt   <= LINE_W'(1);
            r_match_cnt  <= '0;
            r_shift      <= '0;
            r_bit_idx    <= '0;
        end else begin
            r_ser_en     <= 1'b1;
            r_ser_bit    <= w_ser_bit;
            r_line_ready <= w_line_ready;
            r_res_valid  <= w_res_valid;
            r_busy       <= w_busy;

            // Each entry into SHIFT presents the current MSB, then moves the next bit up.
            if (w_accept) begin
                r_shift <= lines.line_data;
            end else if (w_next_state == c_SHIFT) begin
                r_shift <= r_shift << 1;
            end

            if (r_state == c_GAP) begin
                r_bit_idx <= '0;
            end else if (r_state == c_SHIFT) begin
                r_bit_idx <= r_bit_idx + c_BIT_W'(1);
            end

            if (r_state == c_SAMPLE) begin
                r_res_match <= match_in;
            end

            if (w_res_done) begin
                r_line_cnt <= r_line_cnt + LINE_W'(1);
                if (r_res_match && (r_match_cnt != {CNT_W{1'b1}})) begin
                    r_match_cnt <= r_match_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign ser_en           = r_ser_en;
    assign ser_bit          = r_ser_bit;
    assign busy             = r_busy;
    assign match_count      = r_match_cnt;
    assign lines.line_ready = r_line_ready;
    assign lines.res_valid  = r_res_valid;
    assign lines.res_match  = r_res_match;
    assign lines.res_line   = r_line_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regex_line_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_regex_line_streamer
// Description : Directed self-checking bench for regex_line_streamer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regex_line_streamer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regex_line_streamer_if #(.WIDTH(21), .LINE_W(14)) m_if ();
    logic        m_ser_en;
    logic        m_ser_bit;
    logic        m_match_in;
    logic [15:0] m_count;
    logic        m_busy;

    regex_line_streamer #(.WIDTH(21), .LINE_W(14), .CNT_W(16)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .lines       (m_if),
        .ser_en      (m_ser_en),
        .ser_bit     (m_ser_bit),
        .match_in    (m_match_in),
        .match_count (m_count),
        .busy        (m_busy)
    );

    regex_line_streamer_if #(.WIDTH(4), .LINE_W(2)) s_if ();
    logic       s_ser_en;
    logic       s_ser_bit;
    logic       s_match_in;
    logic [1:0] s_count;
    logic       s_busy;

    regex_line_streamer #(.WIDTH(4), .LINE_W(2), .CNT_W(2)) u_dut_small (
        .clk         (clk),
        .reset       (reset),
        .lines       (s_if),
        .ser_en      (s_ser_en),
        .ser_bit     (s_ser_bit),
        .match_in    (s_match_in),
        .match_count (s_count),
        .busy        (s_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // mode 0: match_in low; 1: high only in SAMPLE; 2: high only during SHIFT
    task automatic run_line(input logic [20:0] data, input int mode, input logic exp_m,
                            input logic [13:0] exp_ln, input int hold, input logic [15:0] exp_cnt);
        int cyc;
        cyc = 0;
        while (!m_if.line_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_value("ready_wait", m_if.line_ready, 1);
        m_if.line_data  = data;
        m_if.line_valid = 1'b1;
        m_if.res_ready  = (hold == 0);
        @(negedge clk);
        m_if.line_valid = 1'b0;
        m_if.line_data  = ~data;
        check_value("gap_bit", m_ser_bit, 0);
        check_value("gap_busy", m_busy, 1);
        check_value("gap_ready", m_if.line_ready, 0);
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            m_match_in = (mode == 2);
            check_value($sformatf("shift_bit%0d", k), m_ser_bit, data[20-k]);
        end
        @(negedge clk);
        m_match_in = (mode == 1);
        check_value("sample_bit", m_ser_bit, 0);
        check_value("sample_valid", m_if.res_valid, 0);
        @(negedge clk);
        m_match_in = 1'b0;
        check_value("res_valid", m_if.res_valid, 1);
        check_value("res_match", m_if.res_match, exp_m);
        check_value("res_line", m_if.res_line, exp_ln);
        check_value("res_ready_lo", m_if.line_ready, 0);
        for (int h = 1; h < hold; h++) begin
            @(negedge clk);
            check_value("bp_valid", m_if.res_valid, 1);
            check_value("bp_match", m_if.res_match, exp_m);
            check_value("bp_line", m_if.res_line, exp_ln);
            check_value("bp_ready", m_if.line_ready, 0);
        end
        m_if.res_ready = 1'b1;
        @(negedge clk);
        check_value("done_valid", m_if.res_valid, 0);
        check_value("done_ready", m_if.line_ready, 1);
        check_value("done_busy", m_busy, 0);
        check_value("done_count", m_count, exp_cnt);
    endtask

    initial begin
        logic [1:0] exp_ln [6];
        logic [1:0] exp_cn [6];
        logic       saw_valid;
        int         cyc;

        exp_ln = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        exp_cn = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        reset           = 1'b1;
        m_if.line_data  = '0;
        m_if.line_valid = 1'b0;
        m_if.res_ready  = 1'b0;
        m_match_in      = 1'b0;
        s_if.line_data  = '0;
        s_if.line_valid = 1'b0;
        s_if.res_ready  = 1'b1;
        s_match_in      = 1'b1;

        repeat (3) @(negedge clk);
        check_value("rst_ser_en", m_ser_en, 0);
        check_value("rst_ser_bit", m_ser_bit, 0);
        check_value("rst_ready", m_if.line_ready, 0);
        check_value("rst_valid", m_if.res_valid, 0);
        check_value("rst_match", m_if.res_match, 0);
        check_value("rst_busy", m_busy, 0);
        check_value("rst_line", m_if.res_line, 1);
        check_value("rst_count", m_count, 0);
        check_value("rst_s_line", s_if.res_line, 1);
        reset = 1'b0;
        @(negedge clk);
        check_value("rel_ser_en", m_ser_en, 1);
        check_value("rel_ready", m_if.line_ready, 1);

        run_line(21'b101100000000000000011, 1, 1'b1, 14'd1, 0, 16'd1);
        run_line(21'b011010011100101011100, 2, 1'b0, 14'd2, 0, 16'd1);
        run_line(21'b111111111111111111111, 1, 1'b1, 14'd3, 5, 16'd2);

        // Abort a line in SHIFT bit 7
        m_if.line_data  = 21'h1FFFFF;
        m_if.line_valid = 1'b1;
        @(negedge clk);
        m_if.line_valid = 1'b0;
        for (int k = 0; k < 8; k++) @(negedge clk);
        check_value("pre_rst_busy", m_busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_value("mid_rst_bit", m_ser_bit, 0);
        check_value("mid_rst_busy", m_busy, 0);
        check_value("mid_rst_en", m_ser_en, 0);
        check_value("mid_rst_count", m_count, 0);
        saw_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (m_if.res_valid) saw_valid = 1'b1;
        end
        check_value("mid_rst_no_res", saw_valid, 0);
        run_line(21'b000000000000000000001, 0, 1'b0, 14'd1, 0, 16'd0);

        for (int i = 0; i < 6; i++) begin
            cyc = 0;
            while (!s_if.line_ready && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            check_value("s_ready", s_if.line_ready, 1);
            s_if.line_data  = 4'b1010;
            s_if.line_valid = 1'b1;
            @(negedge clk);
            s_if.line_valid = 1'b0;
            cyc = 1;
            while (!s_if.res_valid && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            check_value($sformatf("s_lat%0d", i), cyc, 7);
            check_value($sformatf("s_line%0d", i), s_if.res_line, exp_ln[i]);
            check_value($sformatf("s_match%0d", i), s_if.res_match, 1);
            @(negedge clk);
            check_value($sformatf("s_count%0d", i), s_count, exp_cn[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
